// File: rtl/control_sequencer.sv
// Six-state ring-counter control sequencer: fetch in T1-T3, execute in T4-T6.
// Bus strobes are active-low combinational decode of the ring state and live opcode.
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h0),
  parameter logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h1),
  parameter logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h2),
  parameter logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE),
  parameter logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    pc_incr,
  output logic                    pc_enablebar,
  output logic                    mar_loadbar,
  output logic                    ram_enablebar,
  output logic                    ir_loadbar,
  output logic                    ir_enablebar,
  output logic                    a_loadbar,
  output logic                    a_enablebar,
  output logic                    b_loadbar,
  output logic                    alu_sub,
  output logic                    alu_enablebar,
  output logic                    out_loadbar,
  output logic [5:0]              tstate,
  output logic                    halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000,
    TH = 6'b000000
  } tstate_e;

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;

  logic is_lda, is_add, is_sub, is_out, is_hlt;
  logic is_mem;

  // Opcode class flags; opcode is decoded live, never latched here.
  always_comb begin
    is_lda = (opcode == OP_LDA);
    is_add = (opcode == OP_ADD);
    is_sub = (opcode == OP_SUB);
    is_out = (opcode == OP_OUT);
    is_hlt = (opcode == OP_HLT);
    is_mem = is_lda | is_add | is_sub;
  end

  // Ring advance; HLT seen in T4 parks the ring at all-zero.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    unique case (state_q)
      T1: state_d = T2;
      T2: state_d = T3;
      T3: state_d = T4;
      T4: begin
        if (is_hlt) begin
          state_d  = TH;
          halted_d = 1'b1;
        end else begin
          state_d = T5;
        end
      end
      T5: state_d = T6;
      T6: state_d = T1;
      TH: begin
        state_d  = TH;
        halted_d = 1'b1;
      end
      default: begin
        state_d  = T1;
        halted_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Strobe decode; reset and halt hold every strobe inactive.
  always_comb begin
    pc_incr       = 1'b0;
    pc_enablebar  = 1'b1;
    mar_loadbar   = 1'b1;
    ram_enablebar = 1'b1;
    ir_loadbar    = 1'b1;
    ir_enablebar  = 1'b1;
    a_loadbar     = 1'b1;
    a_enablebar   = 1'b1;
    b_loadbar     = 1'b1;
    alu_sub       = 1'b0;
    alu_enablebar = 1'b1;
    out_loadbar   = 1'b1;
    if (rstn && !halted_q) begin
      unique case (state_q)
        T1: begin
          pc_enablebar = 1'b0;
          mar_loadbar  = 1'b0;
        end
        T2: pc_incr = 1'b1;
        T3: begin
          ram_enablebar = 1'b0;
          ir_loadbar    = 1'b0;
        end
        T4: begin
          if (is_mem) begin
            ir_enablebar = 1'b0;
            mar_loadbar  = 1'b0;
          end else if (is_out) begin
            a_enablebar = 1'b0;
            out_loadbar = 1'b0;
          end
        end
        T5: begin
          if (is_lda) begin
            ram_enablebar = 1'b0;
            a_loadbar     = 1'b0;
          end else if (is_add || is_sub) begin
            ram_enablebar = 1'b0;
            b_loadbar     = 1'b0;
          end
        end
        T6: begin
          if (is_add || is_sub) begin
            alu_enablebar = 1'b0;
            a_loadbar     = 1'b0;
            alu_sub       = is_sub;
          end
        end
        default: ;
      endcase
    end
  end

  assign tstate = state_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer.
// Checks are immediate assertions sampled on the falling edge.
module tb_control_sequencer;

  logic       clk;
  logic       rstn;
  logic [3:0] opcode;
  logic       pc_incr, pc_enablebar, mar_loadbar, ram_enablebar;
  logic       ir_loadbar, ir_enablebar, a_loadbar, a_enablebar;
  logic       b_loadbar, alu_sub, alu_enablebar, out_loadbar;
  logic [5:0] tstate;
  logic       halted;

  int n_chk = 0;
  int n_fail = 0;

  control_sequencer dut (
    .clk(clk), .rstn(rstn), .opcode(opcode),
    .pc_incr(pc_incr), .pc_enablebar(pc_enablebar),
    .mar_loadbar(mar_loadbar), .ram_enablebar(ram_enablebar),
    .ir_loadbar(ir_loadbar), .ir_enablebar(ir_enablebar),
    .a_loadbar(a_loadbar), .a_enablebar(a_enablebar),
    .b_loadbar(b_loadbar), .alu_sub(alu_sub),
    .alu_enablebar(alu_enablebar), .out_loadbar(out_loadbar),
    .tstate(tstate), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active flags in: incr pc mar ram irl ire al ae bl sub alue outl
  function automatic logic [11:0] sv(
    input bit incr, input bit pc, input bit mar, input bit ram,
    input bit irl, input bit ire, input bit al, input bit ae,
    input bit bl, input bit sub, input bit alue, input bit outl);
    return {incr, ~pc, ~mar, ~ram, ~irl, ~ire, ~al, ~ae,
            ~bl, sub, ~alue, ~outl};
  endfunction

  function automatic logic [11:0] obs();
    return {pc_incr, pc_enablebar, mar_loadbar, ram_enablebar,
            ir_loadbar, ir_enablebar, a_loadbar, a_enablebar,
            b_loadbar, alu_sub, alu_enablebar, out_loadbar};
  endfunction

  task automatic chk(input string tag, input logic [11:0] got,
                     input logic [11:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [5:0] t,
                         input logic [11:0] s, input logic h);
    chk({tag, ".tstate"}, {6'd0, t}, {6'd0, tstate});
    chk({tag, ".strobes"}, obs(), s);
    chk({tag, ".halted"}, {11'd0, halted}, {11'd0, h});
  endtask

  logic [11:0] NONE, S_T1, S_T2, S_T3, S_T4M, S_T4O;
  logic [11:0] S_T5L, S_T5B, S_T6A, S_T6S;

  initial begin
    logic [3:0] ops [7];
    int tidx;
    logic [4:0] en;
    NONE  = sv(0,0,0,0,0,0,0,0,0,0,0,0);
    S_T1  = sv(0,1,1,0,0,0,0,0,0,0,0,0);
    S_T2  = sv(1,0,0,0,0,0,0,0,0,0,0,0);
    S_T3  = sv(0,0,0,1,1,0,0,0,0,0,0,0);
    S_T4M = sv(0,0,1,0,0,1,0,0,0,0,0,0);
    S_T4O = sv(0,0,0,0,0,0,0,1,0,0,0,1);
    S_T5L = sv(0,0,0,1,0,0,1,0,0,0,0,0);
    S_T5B = sv(0,0,0,1,0,0,0,0,1,0,0,0);
    S_T6A = sv(0,0,0,0,0,0,1,0,0,0,1,0);
    S_T6S = sv(0,0,0,0,0,0,1,0,0,1,1,0);

    // 1: reset
    rstn = 1'b0;
    opcode = 4'h0;
    @(posedge clk);
    cyc();
    chk_all("rst", 6'b000001, NONE, 1'b0);
    rstn = 1'b1;
    #1;
    chk_all("rel_t1", 6'b000001, S_T1, 1'b0);

    // 2: LDA
    cyc(); chk_all("lda_t2", 6'b000010, S_T2, 1'b0);
    cyc(); chk_all("lda_t3", 6'b000100, S_T3, 1'b0);
    cyc(); chk_all("lda_t4", 6'b001000, S_T4M, 1'b0);
    cyc(); chk_all("lda_t5", 6'b010000, S_T5L, 1'b0);
    cyc(); chk_all("lda_t6", 6'b100000, NONE, 1'b0);
    cyc(); chk_all("lda_wrap", 6'b000001, S_T1, 1'b0);

    // 3: SUB then ADD
    opcode = 4'h2;
    cyc(); cyc();
    cyc(); chk_all("sub_t4", 6'b001000, S_T4M, 1'b0);
    cyc(); chk_all("sub_t5", 6'b010000, S_T5B, 1'b0);
    cyc(); chk_all("sub_t6", 6'b100000, S_T6S, 1'b0);
    opcode = 4'h1;
    cyc(); cyc(); cyc();
    cyc(); chk_all("add_t4", 6'b001000, S_T4M, 1'b0);
    cyc(); chk_all("add_t5", 6'b010000, S_T5B, 1'b0);
    cyc(); chk_all("add_t6", 6'b100000, S_T6A, 1'b0);

    // OUT
    opcode = 4'hE;
    cyc();
    cyc(); cyc();
    cyc(); chk_all("out_t4", 6'b001000, S_T4O, 1'b0);
    cyc(); chk_all("out_t5", 6'b010000, NONE, 1'b0);
    cyc(); chk_all("out_t6", 6'b100000, NONE, 1'b0);

    // 4: HLT
    opcode = 4'hF;
    cyc(); chk_all("hlt_t1", 6'b000001, S_T1, 1'b0);
    cyc(); cyc();
    cyc(); chk_all("hlt_t4", 6'b001000, NONE, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk_all("halted", 6'b000000, NONE, 1'b1);
    end
    rstn = 1'b0;
    cyc();
    chk_all("hlt_rst", 6'b000001, NONE, 1'b0);
    rstn = 1'b1;
    opcode = 4'h1;
    #1;
    chk_all("hlt_rel", 6'b000001, S_T1, 1'b0);

    // 5: reset during T5 of ADD
    cyc(); cyc(); cyc();
    cyc(); chk_all("mid_t5", 6'b010000, S_T5B, 1'b0);
    rstn = 1'b0;
    #1;
    chk({"mid_rst", ".strobes"}, obs(), NONE);
    cyc();
    chk_all("mid_after", 6'b000001, NONE, 1'b0);
    rstn = 1'b1;
    #1;
    chk_all("mid_rel", 6'b000001, S_T1, 1'b0);
    cyc(); chk_all("mid_t2", 6'b000010, S_T2, 1'b0);

    // 6: random opcodes, contention and NOP checks
    ops = '{4'h0, 4'h1, 4'h2, 4'hE, 4'h5, 4'h3, 4'h9};
    tidx = 1;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      tidx = (tidx + 1) % 6;
      if (tidx == 0) opcode = ops[$urandom_range(6, 0)];
      chk("ring", {6'd0, tstate}, {6'd0, 6'b000001 << tidx});
      en = ~{pc_enablebar, ram_enablebar, ir_enablebar,
             a_enablebar, alu_enablebar};
      chk("contention", {11'd0, $countones(en) > 1}, 12'd0);
      if (tidx >= 3 && opcode == 4'h5)
        chk("undef_nop", obs(), NONE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
